// File: rtl/duty_gate_meas.sv
// rtl/duty_gate_meas.sv - gated reciprocal measurement of period count, window length and high time
// Window opens on a rise of sig and closes on the first rise at or past GATE_CYCLES.
module duty_gate_meas #(
  parameter int unsigned GATE_CYCLES    = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sig,
  input  logic [31:0] high_cnt,
  input  logic        rd_ack,
  output logic        busy,
  output logic        res_valid,
  output logic        res_timeout,
  output logic [31:0] res_periods,
  output logic [31:0] res_total,
  output logic [31:0] res_high
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_MEASURE,
    ST_DONE
  } state_t;

  localparam logic [31:0] GATE     = 32'(GATE_CYCLES);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] LIMIT    = 32'(GATE_CYCLES + TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic        s1_q, s2_q;
  logic [31:0] w_q, w_d;
  logic [31:0] e_q, e_d;
  logic [31:0] p_q, p_d;
  logic [31:0] hs_q, hs_d;
  logic        res_timeout_q, res_timeout_d;
  logic [31:0] res_periods_q, res_periods_d;
  logic [31:0] res_total_q, res_total_d;
  logic [31:0] res_high_q, res_high_d;
  logic        rise;

  assign rise = s1_q & ~s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      w_q           <= '0;
      e_q           <= '0;
      p_q           <= '0;
      hs_q          <= '0;
      res_timeout_q <= 1'b0;
      res_periods_q <= '0;
      res_total_q   <= '0;
      res_high_q    <= '0;
    end else begin
      state_q       <= state_d;
      s1_q          <= sig;
      s2_q          <= s1_q;
      w_q           <= w_d;
      e_q           <= e_d;
      p_q           <= p_d;
      hs_q          <= hs_d;
      res_timeout_q <= res_timeout_d;
      res_periods_q <= res_periods_d;
      res_total_q   <= res_total_d;
      res_high_q    <= res_high_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    w_d           = w_q;
    e_d           = e_q;
    p_d           = p_q;
    hs_d          = hs_q;
    res_timeout_d = res_timeout_q;
    res_periods_d = res_periods_q;
    res_total_d   = res_total_q;
    res_high_d    = res_high_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARMED;
          w_d     = '0;
        end
      end
      ST_ARMED: begin
        // e_q holds the elapsed count of the cycle being evaluated, so MEASURE starts at 1
        if (rise) begin
          state_d = ST_MEASURE;
          hs_d    = high_cnt;
          e_d     = 32'd1;
          p_d     = '0;
        end else if (w_q == TMO_LAST) begin
          state_d       = ST_DONE;
          res_timeout_d = 1'b1;
          res_periods_d = '0;
          res_total_d   = '0;
          res_high_d    = '0;
        end else begin
          w_d = w_q + 32'd1;
        end
      end
      ST_MEASURE: begin
        if (rise && (e_q >= GATE)) begin
          state_d       = ST_DONE;
          res_timeout_d = 1'b0;
          res_periods_d = p_q + 32'd1;
          res_total_d   = e_q;
          res_high_d    = high_cnt - hs_q;
        end else if (e_q == LIMIT) begin
          state_d       = ST_DONE;
          res_timeout_d = 1'b1;
          res_periods_d = p_q;
          res_total_d   = e_q;
          res_high_d    = high_cnt - hs_q;
        end else begin
          e_d = e_q + 32'd1;
          if (rise) begin
            p_d = p_q + 32'd1;
          end
        end
      end
      ST_DONE: begin
        if (rd_ack) begin
          state_d = start ? ST_ARMED : ST_IDLE;
          w_d     = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy        = (state_q == ST_ARMED) || (state_q == ST_MEASURE);
  assign res_valid   = (state_q == ST_DONE);
  assign res_timeout = res_timeout_q;
  assign res_periods = res_periods_q;
  assign res_total   = res_total_q;
  assign res_high    = res_high_q;

endmodule

// File: tb/tb_duty_gate_meas.sv
// tb/tb_duty_gate_meas.sv - randomized bench for duty_gate_meas with an event-level reference model
// The model replays the recorded sig/high_cnt history to locate start and end edges.
module tb_duty_gate_meas;

  localparam int G = 1000;
  localparam int T = 500;
  localparam int HMAX = 65535;

  logic        clk = 1'b0;
  logic        reset, start, sig, rd_ack;
  logic [31:0] high_cnt;
  logic        busy, res_valid, res_timeout;
  logic [31:0] res_periods, res_total, res_high;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bit          sig_h [0:HMAX];
  logic [31:0] hc_h  [0:HMAX];
  int          per_g, high_g, phase_g, stop_g;
  logic [31:0] hc_val;
  bit          exp_to;
  logic [31:0] exp_per, exp_tot, exp_hi;

  always #5 clk = ~clk;

  duty_gate_meas #(.GATE_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .start(start), .sig(sig), .high_cnt(high_cnt),
    .rd_ack(rd_ack), .busy(busy), .res_valid(res_valid), .res_timeout(res_timeout),
    .res_periods(res_periods), .res_total(res_total), .res_high(res_high)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic bit wave(input int e);
    if (per_g == 0 || (stop_g > 0 && e >= stop_g)) return 1'b0;
    return ((e + phase_g) % per_g) < high_g;
  endfunction

  // Drive inputs for the next edge (recorded under that edge's index), then land on the following negedge.
  task automatic tick(input bit rst, input bit st, input bit ack);
    int e;
    bit s;
    e = cyc + 1;
    if (e > HMAX) begin
      $display("FAIL history_overflow: got=%0d expected<=%0d", e, HMAX);
      $fatal(1, "history overflow");
    end
    s = wave(e);
    if (e >= 2) hc_val = hc_val + 32'(sig_h[e-2]);
    sig_h[e] = s;
    hc_h[e]  = hc_val;
    reset = rst; start = st; rd_ack = ack; sig = s; high_cnt = hc_val;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  function automatic bit rise_at(input int k);
    if (k < 2) return 1'b0;
    return sig_h[k-1] && !sig_h[k-2];
  endfunction

  // Start accepted at edge ks; returns expected results and the edge at which DONE is entered.
  task automatic model(input int ks, output bit to, output logic [31:0] per,
                       output logic [31:0] tot, output logic [31:0] hi, output int kd);
    int k0;
    int p;
    k0 = -1;
    for (int k = ks + 1; k <= ks + T; k++) begin
      if (rise_at(k)) begin k0 = k; break; end
    end
    if (k0 < 0) begin
      to = 1'b1; per = 0; tot = 0; hi = 0; kd = ks + T;
      return;
    end
    p = 0;
    for (int j = 1; j <= G + T; j++) begin
      if (rise_at(k0 + j)) begin
        p++;
        if (j >= G) begin
          to = 1'b0; per = 32'(p); tot = 32'(j); hi = hc_h[k0+j] - hc_h[k0]; kd = k0 + j;
          return;
        end
      end
    end
    to = 1'b1; per = 32'(p); tot = 32'(G + T); hi = hc_h[k0+G+T] - hc_h[k0]; kd = k0 + G + T;
  endtask

  task automatic measure(input int ks, input string tag);
    bit done;
    int kd;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick(1'b0, ($urandom_range(0, 15) == 0), 1'b0);
      if (i == 0) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (res_valid) begin done = 1'b1; break; end
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    if (!done) return;
    model(ks, exp_to, exp_per, exp_tot, exp_hi, kd);
    check({tag, "_done_edge"}, 32'(cyc), 32'(kd));
    check({tag, "_timeout"}, 32'(res_timeout), 32'(exp_to));
    check({tag, "_periods"}, res_periods, exp_per);
    check({tag, "_total"}, res_total, exp_tot);
    check({tag, "_high"}, res_high, exp_hi);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_hold_periods"}, res_periods, exp_per);
    check({tag, "_hold_total"}, res_total, exp_tot);
  endtask

  task automatic release_res(input bit rearm, input string tag);
    tick(1'b0, rearm, 1'b1);
    if (rearm) check({tag, "_rearm_busy"}, 32'(busy), 32'd1);
    else       check({tag, "_ack_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_ack_total"}, res_total, exp_tot);
    check({tag, "_ack_high"}, res_high, exp_hi);
  endtask

  task automatic set_wave(input int p, input int h, input int ph);
    per_g = p; high_g = h; phase_g = ph; stop_g = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_timeout"}, 32'(res_timeout), 32'd0);
    check({tag, "_periods"}, res_periods, 32'd0);
    check({tag, "_total"}, res_total, 32'd0);
    check({tag, "_high"}, res_high, 32'd0);
  endtask

  initial begin
    int ks;
    int p;
    reset = 1'b1; start = 1'b0; rd_ack = 1'b0; sig = 1'b0;
    hc_val = $urandom; high_cnt = hc_val;
    set_wave(0, 0, 0);
    @(negedge clk);
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    check_zero("reset");

    repeat (3) tick(1'b0, 1'b0, 1'b1);
    check("idle_ack_valid", 32'(res_valid), 32'd0);
    check("idle_ack_busy", 32'(busy), 32'd0);

    set_wave(100, 25, $urandom_range(0, 99));
    tick(1'b0, 1'b1, 1'b0); ks = cyc;
    measure(ks, "p100");
    check("p100_const_periods", res_periods, 32'd10);
    check("p100_const_total", res_total, 32'd1000);
    check("p100_const_high", res_high, 32'd250);
    check("p100_const_timeout", 32'(res_timeout), 32'd0);
    release_res(1'b0, "p100");

    set_wave(300, 75, $urandom_range(0, 299));
    tick(1'b0, 1'b1, 1'b0); ks = cyc;
    measure(ks, "p300");
    check("p300_const_periods", res_periods, 32'd4);
    check("p300_const_total", res_total, 32'd1200);
    check("p300_const_high", res_high, 32'd300);
    release_res(1'b1, "p300");
    ks = cyc;
    measure(ks, "rearm");
    release_res(1'b0, "rearm");

    set_wave(0, 0, 0);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0); ks = cyc;
    measure(ks, "armed_to");
    check("armed_to_latency", 32'(exp_tot), 32'd0);
    check("armed_to_const_timeout", 32'(res_timeout), 32'd1);
    check("armed_to_const_periods", res_periods, 32'd0);
    release_res(1'b0, "armed_to");

    set_wave(100, 25, $urandom_range(0, 99));
    tick(1'b0, 1'b1, 1'b0); ks = cyc;
    stop_g = ks + 450;
    measure(ks, "stop");
    check("stop_const_timeout", 32'(res_timeout), 32'd1);
    check("stop_const_total", res_total, 32'(G + T));
    release_res(1'b0, "stop");

    set_wave(100, 25, $urandom_range(0, 99));
    hc_val = 32'hFFFF_FF00 - 32'd10;
    tick(1'b0, 1'b1, 1'b0); ks = cyc;
    measure(ks, "wrap");
    check("wrap_const_high", res_high, 32'd250);
    release_res(1'b0, "wrap");

    ks = cyc + 3;
    set_wave(100, 25, (100 - ((ks - 1) % 100)) % 100);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("coinc_ks", 32'(cyc), 32'(ks));
    measure(ks, "coinc");
    check("coinc_const_edge", 32'(cyc - 3 - ks), 32'd1100);
    release_res(1'b0, "coinc");

    set_wave(100, 25, $urandom_range(0, 99));
    tick(1'b0, 1'b1, 1'b0);
    repeat (300) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check_zero("mid_reset");
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0); ks = cyc;
    measure(ks, "post_reset");
    release_res(1'b0, "post_reset");

    for (int n = 0; n < 6; n++) begin
      p = $urandom_range(20, 400);
      set_wave(p, $urandom_range(1, p - 1), $urandom_range(0, p - 1));
      tick(1'b0, 1'b1, 1'b0); ks = cyc;
      if ($urandom_range(0, 1) == 1) stop_g = ks + $urandom_range(0, 1400);
      measure(ks, $sformatf("rnd%0d", n));
      release_res(1'b0, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
